issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Parametrised successor of the dual-issue launch stage: N-wide in-order issue with a per-register pending-write scoreboard.
- Sits between decode and the execute pipes.
- Each cycle it accepts the longest hazard-free prefix of the decoded group and registers it toward execute.
- Write-back ports clear scoreboard entries; flush drops the registered group and clears the scoreboard.

Parameters:
- ISSUE_WIDTH, 2, slots per group (1..4); slot 0 is oldest.
- DECODE_WIDTH, 64, decode bus width per slot.
- WB_PORTS, 2, write-back clear ports.
- NREG, 32, architectural registers; x0 is never tracked.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  drop registered group; clear scoreboard
- in_valid  in  ISSUE_WIDTH  per-slot valid; must be a contiguous prefix
- in_pc  in  32*ISSUE_WIDTH  slot PCs, flattened, slot 0 in LSBs
- in_npc  in  32*ISSUE_WIDTH  predicted next PCs
- in_inst  in  32*ISSUE_WIDTH  raw instructions
- in_decode  in  DECODE_WIDTH*ISSUE_WIDTH  decode bundles
- in_accept  out  ISSUE_WIDTH  combinational per-slot accept mask, always a prefix
- out_ready  in  1  execute can take a new group
- out_valid  out  ISSUE_WIDTH  registered issued-slot mask
- out_pc, out_npc, out_inst  out  32*ISSUE_WIDTH  registered copies
- out_decode  out  DECODE_WIDTH*ISSUE_WIDTH  registered copy
- wb_valid  in  WB_PORTS  write-back strobes
- wb_rd  in  5*WB_PORTS  write-back destination registers
- busy_mask  out  NREG  current scoreboard, for debug/perf

Behaviour:
- Reset (async): out_valid=0, all out_* data=0, scoreboard=0. in_accept is 0 while rst is high.
- Decode fields:
  - rd=[36:32], rs1=[41:37], rs2=[46:42], regw=[50]
  - uses_rs1=[47], uses_rs2=[48], is_mem=[51]
- Effective pending (eff): scoreboard with this cycle's valid wb_rd bits cleared. This is write-back bypass: a register written back this cycle is readable this cycle.
- Slot i is eligible when all of the following hold:
  - in_valid[i] and out_ready and !flush
  - all slots j<i are accepted
  - no RAW on the scoreboard: uses_rsK and rsK!=0 and eff[rsK] → stall
  - no WAW on the scoreboard: regw and rd!=0 and eff[rd] → stall
  - no intra-group RAW/WAW: any older accepted slot j with regw and rd!=0 matching this slot's used rs or rd → stall
  - structural: at most one is_mem slot per group; a second is_mem slot stalls
- in_accept = eligible prefix; the first ineligible slot blocks all younger slots.
- Registered stage, on a clock edge:
  - flush: out_valid←0, scoreboard←0 (flush overrides everything).
  - else if out_ready: out_* ← inputs, out_valid←in_accept.
  - else: hold out_*.
- Scoreboard update, on a clock edge without flush, per register r:
  - next = (sb[r] & ~wbclr[r]) | set[r]
  - set[r]: any accepted slot with regw and rd==r, r!=0
  - set wins over a same-cycle clear of the same register
- x0 never enters the scoreboard. wb_rd=0 is ignored.
- Latency: decode → out_* is 1 cycle. A dependent of a 1-cycle producer issues the cycle its write-back arrives (bypass).
- Flush contract: the backend asserts flush only once all non-killed older writers have written back. Clearing the whole scoreboard is therefore safe.
- Verification assertions:
  - in_valid must be a prefix; a non-prefix pattern is an assertion failure.
  - wb to a non-pending register is an assertion warning and is otherwise ignored.

Decomposition:
- Package issue_pkg:
  - decode field bit-position constants (RD_LSB, RS1_LSB, RS2_LSB, REGW_BIT, USE1_BIT, USE2_BIT, MEM_BIT)
  - REG_IDX_W=5
  - slot-extract helper functions
- Sub-module scoreboard_regfile:
  - NREG-bit set/clear register with async reset and flush clear
  - exposes the eff vector and busy_mask
- The issue-select logic stays in the top module.

Test Plan:
- Independent pair (addi x1; addi x2), empty scoreboard, out_ready=1 → in_accept=2'b11; next cycle out_valid=11; busy_mask bits 1 and 2 set.
- Intra-group RAW (addi x5; add x6,x5,x7) → in_accept=01. Next cycle the decode stage re-presents the add in slot 0 → add stalls while busy[5]=1. Drive wb_valid=1, wb_rd=5 → add accepted that same cycle.
- Two loads in one group → in_accept=01. Second load is accepted on the next cycle.
- out_ready=0 for 3 cycles with a valid group → in_accept=0; out_* unchanged; scoreboard unchanged.
- Same-cycle set/clear: wb_rd=3 while accepted slot 0 writes x3 → busy[3]=1 after the edge. rd=0 writer → busy_mask unchanged.
- flush with busy_mask=0x0000_00F0 and out_valid=11 → next cycle busy_mask=0, out_valid=0. Assert rst mid-group → outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/issue_pkg.sv
// Shared decode-field layout and slot helpers for the N-wide issue stage.
// Only the low DEC_USED_W bits of each decode bundle carry fields the scoreboard reads.
package issue_pkg;

   localparam int REG_IDX_W  = 5;
   localparam int RD_LSB     = 32;
   localparam int RS1_LSB    = 37;
   localparam int RS2_LSB    = 42;
   localparam int USE1_BIT   = 47;
   localparam int USE2_BIT   = 48;
   localparam int REGW_BIT   = 50;
   localparam int MEM_BIT    = 51;
   localparam int DEC_USED_W = 52;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [REG_IDX_W-1:0] rs1;
      logic [REG_IDX_W-1:0] rs2;
      logic                 use1;
      logic                 use2;
      logic                 regw;
      logic                 mem;
   } slot_fields_t;

   function automatic slot_fields_t unpack_decode(input logic [DEC_USED_W-1:0] d);
      slot_fields_t f;
      f.rd   = d[RD_LSB  +: REG_IDX_W];
      f.rs1  = d[RS1_LSB +: REG_IDX_W];
      f.rs2  = d[RS2_LSB +: REG_IDX_W];
      f.use1 = d[USE1_BIT];
      f.use2 = d[USE2_BIT];
      f.regw = d[REGW_BIT];
      f.mem  = d[MEM_BIT];
      return f;
   endfunction

   // A slot writes a tracked register only when regw is set and rd is not x0.
   function automatic logic writes_reg(input slot_fields_t f);
      return f.regw && (f.rd != '0);
   endfunction

endpackage

// File: rtl/scoreboard_regfile.sv
// Pending-write bit per architectural register; write-back clears are bypassed
// into eff so a consumer can issue in the same cycle its producer writes back.
module scoreboard_regfile
   import issue_pkg::*;
#(
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic [NREG-1:0] set_mask,
   input  logic [NREG-1:0] clr_mask,
   output logic [NREG-1:0] eff,
   output logic [NREG-1:0] busy_mask
);

   localparam logic [NREG-1:0] TRACK_MASK = ~(NREG'(1));

   logic [NREG-1:0] sb;

   assign eff       = sb & ~clr_mask;
   assign busy_mask = sb;

   // Set is ORed after the clear so a same-cycle new writer keeps its entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb <= '0;
      end else if (flush) begin
         sb <= '0;
      end else begin
         sb <= (eff | set_mask) & TRACK_MASK;
      end
   end

endmodule

// File: rtl/issue_scoreboard.sv
// N-wide in-order issue stage: accepts the longest hazard-free prefix of the
// decoded group each cycle and registers it toward the execute pipes.
module issue_scoreboard
   import issue_pkg::*;
#(
   parameter int ISSUE_WIDTH  = 2,
   parameter int DECODE_WIDTH = 64,
   parameter int WB_PORTS     = 2,
   parameter int NREG         = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic [ISSUE_WIDTH-1:0]           in_valid,
   input  logic [32*ISSUE_WIDTH-1:0]        in_pc,
   input  logic [32*ISSUE_WIDTH-1:0]        in_npc,
   input  logic [32*ISSUE_WIDTH-1:0]        in_inst,
   input  logic [DECODE_WIDTH*ISSUE_WIDTH-1:0] in_decode,
   output logic [ISSUE_WIDTH-1:0]           in_accept,
   input  logic                             out_ready,
   output logic [ISSUE_WIDTH-1:0]           out_valid,
   output logic [32*ISSUE_WIDTH-1:0]        out_pc,
   output logic [32*ISSUE_WIDTH-1:0]        out_npc,
   output logic [32*ISSUE_WIDTH-1:0]        out_inst,
   output logic [DECODE_WIDTH*ISSUE_WIDTH-1:0] out_decode,
   input  logic [WB_PORTS-1:0]              wb_valid,
   input  logic [REG_IDX_W*WB_PORTS-1:0]    wb_rd,
   output logic [NREG-1:0]                  busy_mask
);

   // Handshake: in_accept[i] means slot i is consumed at this edge; the decode
   // stage re-presents unaccepted slots shifted down to slot 0 next cycle.
   // out_valid is a registered mask that execute consumes whenever out_ready is high.

   logic [NREG-1:0]      eff;
   logic [NREG-1:0]      set_mask;
   logic [NREG-1:0]      clr_mask;
   logic                 wb_stray;
   logic                 valid_is_prefix;
   slot_fields_t         f;
   logic                 stall;
   logic                 blocked;
   logic                 mem_taken;
   logic [REG_IDX_W-1:0] wb_idx;

   scoreboard_regfile #(.NREG(NREG)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .set_mask  (set_mask),
      .clr_mask  (clr_mask),
      .eff       (eff),
      .busy_mask (busy_mask)
   );

   always_comb begin
      clr_mask = '0;
      wb_stray = 1'b0;
      wb_idx   = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
         wb_idx = wb_rd[p*REG_IDX_W +: REG_IDX_W];
         if (wb_valid[p] && (wb_idx != '0)) begin
            clr_mask[wb_idx] = 1'b1;
            if (!busy_mask[wb_idx]) begin
               wb_stray = 1'b1;
            end
         end
      end
   end

   // set_mask doubles as the set of registers written by older accepted slots,
   // which is exactly what the intra-group RAW/WAW check needs.
   always_comb begin
      in_accept = '0;
      set_mask  = '0;
      blocked   = rst || flush || !out_ready;
      mem_taken = 1'b0;
      f         = '0;
      stall     = 1'b0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         f     = unpack_decode(in_decode[i*DECODE_WIDTH +: DEC_USED_W]);
         stall = blocked || !in_valid[i];
         if (f.use1 && (f.rs1 != '0) && (eff[f.rs1] || set_mask[f.rs1])) begin
            stall = 1'b1;
         end
         if (f.use2 && (f.rs2 != '0) && (eff[f.rs2] || set_mask[f.rs2])) begin
            stall = 1'b1;
         end
         if (writes_reg(f) && (eff[f.rd] || set_mask[f.rd])) begin
            stall = 1'b1;
         end
         if (f.mem && mem_taken) begin
            stall = 1'b1;
         end
         if (stall) begin
            blocked = 1'b1;
         end else begin
            in_accept[i] = 1'b1;
            if (writes_reg(f)) begin
               set_mask[f.rd] = 1'b1;
            end
            if (f.mem) begin
               mem_taken = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= '0;
         out_pc     <= '0;
         out_npc    <= '0;
         out_inst   <= '0;
         out_decode <= '0;
      end else if (flush) begin
         out_valid <= '0;
      end else if (out_ready) begin
         out_valid  <= in_accept;
         out_pc     <= in_pc;
         out_npc    <= in_npc;
         out_inst   <= in_inst;
         out_decode <= in_decode;
      end
   end

   always_comb begin
      valid_is_prefix = 1'b1;
      for (int i = 1; i < ISSUE_WIDTH; i++) begin
         if (in_valid[i] && !in_valid[i-1]) begin
            valid_is_prefix = 1'b0;
         end
      end
   end

   a_valid_prefix: assert property (@(posedge clk) disable iff (rst) valid_is_prefix)
      else $error("in_valid is not a contiguous prefix: %b", in_valid);

   a_wb_pending: assert property (@(posedge clk) disable iff (rst) !wb_stray)
      else $warning("write-back to a register that is not pending");

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed table of the key hazard scenarios, an
// asynchronous reset check, then randomized groups against a queue-based model.
module tb_issue_scoreboard;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic [1:0]   in_valid = '0;
   logic [63:0]  in_pc = '0;
   logic [63:0]  in_npc = '0;
   logic [63:0]  in_inst = '0;
   logic [127:0] in_decode = '0;
   logic [1:0]   in_accept;
   logic         out_ready = 1'b0;
   logic [1:0]   out_valid;
   logic [63:0]  out_pc;
   logic [63:0]  out_npc;
   logic [63:0]  out_inst;
   logic [127:0] out_decode;
   logic [1:0]   wb_valid = '0;
   logic [9:0]   wb_rd = '0;
   logic [31:0]  busy_mask;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [31:0]  m_sb;
   logic [1:0]   m_ov;
   logic [63:0]  m_pc, m_npc, m_inst;
   logic [127:0] m_dec;

   typedef struct {
      logic [1:0]  valid;
      logic [63:0] d0;
      logic [63:0] d1;
      logic        ready;
      logic        fl;
      logic [1:0]  wbv;
      logic [4:0]  wb0;
      logic [4:0]  wb1;
      logic [1:0]  exp_acc;
      logic [1:0]  exp_ov;
      logic [31:0] exp_busy;
   } vec_t;

   vec_t tbl[$];

   issue_scoreboard dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_pc      (in_pc),
      .in_npc     (in_npc),
      .in_inst    (in_inst),
      .in_decode  (in_decode),
      .in_accept  (in_accept),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_pc     (out_pc),
      .out_npc    (out_npc),
      .out_inst   (out_inst),
      .out_decode (out_decode),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .busy_mask  (busy_mask)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] dec(input int rd, input int rs1, input int rs2,
                                       input bit u1, input bit u2, input bit w, input bit m);
      logic [63:0] d;
      d = '0;
      d[36:32] = rd[4:0];
      d[41:37] = rs1[4:0];
      d[46:42] = rs2[4:0];
      d[47] = u1;
      d[48] = u2;
      d[50] = w;
      d[51] = m;
      return d;
   endfunction

   function automatic logic [63:0] addi(input int rd, input int rs1);
      return dec(rd, rs1, 0, 1, 0, 1, 0);
   endfunction

   function automatic logic [63:0] add(input int rd, input int rs1, input int rs2);
      return dec(rd, rs1, rs2, 1, 1, 1, 0);
   endfunction

   function automatic logic [63:0] ld(input int rd, input int rs1);
      return dec(rd, rs1, 0, 1, 0, 1, 1);
   endfunction

   function automatic bit in_list(input int q[$], input int r);
      foreach (q[k]) if (q[k] == r) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Walk the group oldest-first; stop at the first slot that breaks a rule.
   function automatic void model_accept(output logic [1:0] acc, output logic [31:0] setm,
                                        output logic [31:0] clrm);
      logic [31:0] pend;
      logic [63:0] d;
      int          writers[$];
      int          rd, rs1, rs2;
      bit          u1, u2, w, m, mem_used;
      clrm = '0;
      for (int p = 0; p < 2; p++) begin
         if (wb_valid[p] && wb_rd[p*5 +: 5] != 5'd0) clrm[wb_rd[p*5 +: 5]] = 1'b1;
      end
      pend = m_sb & ~clrm;
      acc = '0;
      setm = '0;
      mem_used = 1'b0;
      if (!out_ready || flush) return;
      for (int i = 0; i < 2; i++) begin
         d   = in_decode[i*64 +: 64];
         rd  = int'(d[36:32]);
         rs1 = int'(d[41:37]);
         rs2 = int'(d[46:42]);
         u1  = d[47];
         u2  = d[48];
         w   = d[50];
         m   = d[51];
         if (!in_valid[i]) break;
         if (u1 && rs1 != 0 && (pend[rs1] || in_list(writers, rs1))) break;
         if (u2 && rs2 != 0 && (pend[rs2] || in_list(writers, rs2))) break;
         if (w && rd != 0 && (pend[rd] || in_list(writers, rd))) break;
         if (m && mem_used) break;
         acc[i] = 1'b1;
         if (w && rd != 0) begin
            writers.push_back(rd);
            setm[rd] = 1'b1;
         end
         if (m) mem_used = 1'b1;
      end
   endfunction

   task automatic model_reset();
      m_sb = '0; m_ov = '0; m_pc = '0; m_npc = '0; m_inst = '0; m_dec = '0;
   endtask

   // Called just after an edge with inputs already driven; returns just after the next edge.
   task automatic run_cycle(input string tag, input bit use_tbl, input logic [1:0] t_acc,
                            input logic [1:0] t_ov, input logic [31:0] t_busy);
      logic [1:0]  acc;
      logic [31:0] setm, clrm;
      #1;
      model_accept(acc, setm, clrm);
      chk({tag, ".accept"}, in_accept, acc);
      if (use_tbl) chk({tag, ".accept_tbl"}, in_accept, t_acc);
      if (flush) begin
         m_sb = '0;
         m_ov = '0;
      end else begin
         m_sb = (m_sb & ~clrm) | setm;
         if (out_ready) begin
            m_ov = acc; m_pc = in_pc; m_npc = in_npc; m_inst = in_inst; m_dec = in_decode;
         end
      end
      @(posedge clk);
      #1;
      chk({tag, ".out_valid"}, out_valid, m_ov);
      chk({tag, ".out_pc"}, out_pc, m_pc);
      chk({tag, ".out_npc"}, out_npc, m_npc);
      chk({tag, ".out_inst"}, out_inst, m_inst);
      chk({tag, ".out_decode"}, out_decode, m_dec);
      chk({tag, ".busy_mask"}, busy_mask, m_sb);
      if (use_tbl) begin
         chk({tag, ".out_valid_tbl"}, out_valid, t_ov);
         chk({tag, ".busy_tbl"}, busy_mask, t_busy);
      end
   endtask

   task automatic add_row(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                          input logic rdy, input logic fl, input logic [1:0] wbv,
                          input logic [4:0] wb0, input logic [4:0] wb1, input logic [1:0] ea,
                          input logic [1:0] eo, input logic [31:0] eb);
      vec_t r;
      r.valid = v; r.d0 = d0; r.d1 = d1; r.ready = rdy; r.fl = fl; r.wbv = wbv;
      r.wb0 = wb0; r.wb1 = wb1; r.exp_acc = ea; r.exp_ov = eo; r.exp_busy = eb;
      tbl.push_back(r);
   endtask

   task automatic random_inputs();
      int          n;
      int          pend_q[$];
      logic [63:0] d;
      n = $urandom_range(0, 2);
      in_valid = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
      for (int i = 0; i < 2; i++) begin
         d = dec($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 2) == 0);
         d[31:0]  = $urandom;
         d[63:52] = 12'($urandom);
         d[49]    = $urandom_range(0, 1);
         in_decode[i*64 +: 64] = d;
      end
      in_pc     = {$urandom, $urandom};
      in_npc    = {$urandom, $urandom};
      in_inst   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      for (int r = 1; r < 32; r++) if (m_sb[r]) pend_q.push_back(r);
      wb_valid = '0;
      wb_rd    = '0;
      for (int p = 0; p < 2; p++) begin
         if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            wb_valid[p]     = 1'b1;
            wb_rd[p*5 +: 5] = 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
         end
      end
   endtask

   initial begin
      model_reset();
      // Directed scenarios; scoreboard state carries from row to row.
      add_row(2'b11, addi(1, 0),   addi(2, 0),    1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 32'h0000_0006);
      add_row(2'b11, addi(5, 0),   add(6, 5, 7),  1, 0, 2'b00, 0, 0, 2'b01, 2'b01, 32'h0000_0026);
      add_row(2'b01, add(6, 5, 7), 64'd0,         1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h0000_0026);
      add_row(2'b01, add(6, 5, 7), 64'd0,         1, 0, 2'b01, 5, 0, 2'b01, 2'b01, 32'h0000_0046);
      add_row(2'b11, ld(8, 0),     ld(9, 0),      1, 0, 2'b00, 0, 0, 2'b01, 2'b01, 32'h0000_0146);
      add_row(2'b01, ld(9, 0),     64'd0,         1, 0, 2'b00, 0, 0, 2'b01, 2'b01, 32'h0000_0346);
      add_row(2'b11, addi(10, 0),  addi(11, 0),   0, 0, 2'b00, 0, 0, 2'b00, 2'b01, 32'h0000_0346);
      add_row(2'b11, addi(10, 0),  addi(11, 0),   0, 0, 2'b00, 0, 0, 2'b00, 2'b01, 32'h0000_0346);
      add_row(2'b11, addi(10, 0),  addi(11, 0),   0, 0, 2'b00, 0, 0, 2'b00, 2'b01, 32'h0000_0346);
      add_row(2'b00, 64'd0,        64'd0,         1, 0, 2'b11, 1, 2, 2'b00, 2'b00, 32'h0000_0340);
      add_row(2'b00, 64'd0,        64'd0,         1, 0, 2'b11, 6, 8, 2'b00, 2'b00, 32'h0000_0200);
      add_row(2'b01, addi(3, 0),   64'd0,         1, 0, 2'b01, 9, 0, 2'b01, 2'b01, 32'h0000_0008);
      add_row(2'b01, addi(3, 0),   64'd0,         1, 0, 2'b01, 3, 0, 2'b01, 2'b01, 32'h0000_0008);
      add_row(2'b01, addi(0, 0),   64'd0,         1, 0, 2'b00, 0, 0, 2'b01, 2'b01, 32'h0000_0008);
      add_row(2'b00, 64'd0,        64'd0,         1, 0, 2'b01, 3, 0, 2'b00, 2'b00, 32'h0000_0000);
      add_row(2'b11, addi(4, 0),   addi(5, 0),    1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 32'h0000_0030);
      add_row(2'b11, addi(6, 0),   addi(7, 0),    1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 32'h0000_00F0);
      add_row(2'b11, addi(1, 0),   addi(2, 0),    1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 32'h0000_0000);

      // Reset state, including in_accept held low while rst is high.
      in_valid  = 2'b11;
      in_decode = {addi(2, 0), addi(1, 0)};
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.in_accept", in_accept, 2'b00);
      chk("reset.out_valid", out_valid, 2'b00);
      chk("reset.out_pc", out_pc, 64'd0);
      chk("reset.out_decode", out_decode, 128'd0);
      chk("reset.busy_mask", busy_mask, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      // The cycle just taken registered the pending group; resync the model.
      m_ov = 2'b11; m_pc = in_pc; m_npc = in_npc; m_inst = in_inst; m_dec = in_decode;
      m_sb = 32'h0000_0006;
      chk("post_reset.out_valid", out_valid, m_ov);
      chk("post_reset.busy_mask", busy_mask, m_sb);
      flush = 1'b1;
      in_valid = 2'b00;
      run_cycle("clear", 0, 2'b00, 2'b00, 32'd0);
      flush = 1'b0;

      for (int k = 0; k < tbl.size(); k++) begin
         in_valid  = tbl[k].valid;
         in_decode = {tbl[k].d1, tbl[k].d0};
         in_pc     = {$urandom, $urandom};
         in_npc    = {$urandom, $urandom};
         in_inst   = {$urandom, $urandom};
         out_ready = tbl[k].ready;
         flush     = tbl[k].fl;
         wb_valid  = tbl[k].wbv;
         wb_rd     = {tbl[k].wb1, tbl[k].wb0};
         run_cycle($sformatf("row%0d", k), 1, tbl[k].exp_acc, tbl[k].exp_ov, tbl[k].exp_busy);
      end
      flush    = 1'b0;
      wb_valid = '0;

      // Asynchronous reset in the middle of a cycle with a live group.
      in_valid  = 2'b11;
      in_decode = {addi(2, 0), addi(1, 0)};
      out_ready = 1'b1;
      run_cycle("pre_rst", 1, 2'b11, 2'b11, 32'h0000_0006);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst.out_valid", out_valid, 2'b00);
      chk("async_rst.out_pc", out_pc, 64'd0);
      chk("async_rst.out_inst", out_inst, 64'd0);
      chk("async_rst.busy_mask", busy_mask, 32'd0);
      chk("async_rst.in_accept", in_accept, 2'b00);
      in_valid = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      for (int k = 0; k < 400; k++) begin
         random_inputs();
         run_cycle($sformatf("rand%0d", k), 0, 2'b00, 2'b00, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
